// File: rtl/shift_pkg.sv
// Shared types for the operand-2 shifter pipeline.
// Shift-type codes, special-case codes and the stage-1 bundle.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [2:0] {
        SC_PASS,
        SC_ZERO,
        SC_SIGN,
        SC_RRX,
        SC_NORMAL
    } specialCase_e;

    typedef struct packed {
        logic [1:0]   shType;
        logic [4:0]   amt;
        specialCase_e code;
        logic         killC;
        logic [31:0]  data;
        logic         cFlag;
    } s1Stage_t;

    localparam s1Stage_t S1_RESET = '{
        shType: SH_LSL,
        amt:    5'd0,
        code:   SC_PASS,
        killC:  1'b0,
        data:   32'd0,
        cFlag:  1'b0
    };

endpackage

// File: rtl/shift_unit_pipe_rotr32.sv
// Combinational 32-bit rotate-right, five mux levels.
module rotr32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] y
);

    logic [31:0] l0;
    logic [31:0] l1;
    logic [31:0] l2;
    logic [31:0] l3;

    assign l0 = amt[0] ? {data[0], data[31:1]}  : data;
    assign l1 = amt[1] ? {l0[1:0], l0[31:2]}    : l0;
    assign l2 = amt[2] ? {l1[3:0], l1[31:4]}    : l1;
    assign l3 = amt[3] ? {l2[7:0], l2[31:8]}    : l2;
    assign y  = amt[4] ? {l3[15:0], l3[31:16]}  : l3;

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage ARM operand-2 shifter with valid/ready on both sides.
// Define SHIFTER_RRX_EN to make immediate ROR #0 perform RRX.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      ShIn,
    input  logic [1:0]       Sh,
    input  logic             ShReg,
    input  logic [4:0]       Shamt5,
    input  logic [7:0]       RsAmt,
    input  logic             CFlag,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      ShOut,
    output logic             ShCarry,
    output logic [TAG_W-1:0] OutTag
);

    logic             rstDone;
    logic             s1Valid;
    s1Stage_t         s1;
    logic [TAG_W-1:0] s1Tag;
    s1Stage_t         dec;
    logic             s2Adv;
    logic             accept;

    logic [4:0] amt5;
    logic       amtZero;
    logic       amtGe32;
    logic       amtEq32;

    assign s2Adv   = !OutValid || OutReady;
    assign InReady = rstDone && (!s1Valid || s2Adv);
    assign accept  = InValid && InReady;

    assign amt5    = ShReg ? RsAmt[4:0] : Shamt5;
    assign amtZero = ShReg ? (RsAmt == 8'd0) : (Shamt5 == 5'd0);
    assign amtGe32 = ShReg && (RsAmt[7:5] != 3'd0);
    assign amtEq32 = ShReg && (RsAmt == 8'd32);

    // LSL by n is a rotate-right by (32-n) mod 32 with low bits masked.
    always_comb begin
        dec        = S1_RESET;
        dec.shType = Sh;
        dec.data   = ShIn;
        dec.cFlag  = CFlag;
        dec.code   = SC_NORMAL;
        dec.amt    = (Sh == SH_LSL) ? 5'd0 - amt5 : amt5;
        unique case (1'b1)
            ShReg && amtZero: begin
                dec.code = SC_PASS;
            end
            !ShReg && amtZero: begin
                unique case (Sh)
                    SH_LSL: dec.code = SC_PASS;
                    SH_LSR: dec.code = SC_ZERO;
                    SH_ASR: dec.code = SC_SIGN;
                    default: begin
`ifdef SHIFTER_RRX_EN
                        dec.code = SC_RRX;
`else
                        dec.code = SC_PASS;
`endif
                    end
                endcase
            end
            amtGe32: begin
                unique case (Sh)
                    SH_LSL, SH_LSR: begin
                        dec.code  = SC_ZERO;
                        dec.amt   = 5'd0;
                        dec.killC = !amtEq32;
                    end
                    SH_ASR:  dec.code = SC_SIGN;
                    default: dec.code = SC_NORMAL;
                endcase
            end
            default: begin
                dec.code = SC_NORMAL;
            end
        endcase
    end

    logic [31:0] rot;
    logic [31:0] keep;
    logic [4:0]  lslN;
    logic        sign;
    logic        rotC;
    logic [31:0] shRes;
    logic        cRes;

    rotr32 uRot (
        .data (s1.data),
        .amt  (s1.amt),
        .y    (rot)
    );

    assign lslN = 5'd0 - s1.amt;
    assign sign = s1.data[31];
    // After the rotate, the last bit shifted out sits at bit 0 for LSL, else bit 31.
    assign rotC = (s1.shType == SH_LSL) ? rot[0] : rot[31];

    always_comb begin
        unique case (s1.shType)
            SH_LSL:  keep = 32'hFFFF_FFFF << lslN;
            SH_LSR,
            SH_ASR:  keep = 32'hFFFF_FFFF >> s1.amt;
            default: keep = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        shRes = s1.data;
        cRes  = s1.cFlag;
        unique case (s1.code)
            SC_PASS: begin
                shRes = s1.data;
                cRes  = s1.cFlag;
            end
            SC_ZERO: begin
                shRes = 32'd0;
                cRes  = s1.killC ? 1'b0 : rotC;
            end
            SC_SIGN: begin
                shRes = {32{sign}};
                cRes  = sign;
            end
            SC_RRX: begin
                shRes = {s1.cFlag, s1.data[31:1]};
                cRes  = s1.data[0];
            end
            default: begin
                shRes = (rot & keep)
                      | (~keep & {32{(s1.shType == SH_ASR) && sign}});
                cRes  = rotC;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rstDone  <= 1'b0;
            s1Valid  <= 1'b0;
            s1       <= S1_RESET;
            s1Tag    <= '0;
            OutValid <= 1'b0;
            ShOut    <= 32'd0;
            ShCarry  <= 1'b0;
            OutTag   <= '0;
        end else begin
            rstDone <= 1'b1;
            if (InReady) begin
                s1Valid <= InValid;
            end
            if (accept) begin
                s1    <= dec;
                s1Tag <= InTag;
            end
            if (s2Adv) begin
                OutValid <= s1Valid;
            end
            if (s2Adv && s1Valid) begin
                ShOut   <= shRes;
                ShCarry <= cRes;
                OutTag  <= s1Tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: directed cases plus a
// randomized stream scored against a plain-arithmetic shift model.
module tb_shift_unit_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        InValid;
    logic        InReady;
    logic [31:0] ShIn;
    logic [1:0]  Sh;
    logic        ShReg;
    logic [4:0]  Shamt5;
    logic [7:0]  RsAmt;
    logic        CFlag;
    logic [3:0]  InTag;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ShOut;
    logic        ShCarry;
    logic [3:0]  OutTag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] x;
        logic [1:0]  sh;
        logic        isReg;
        logic [4:0]  n;
        logic [7:0]  a;
        logic        cf;
        logic [3:0]  tag;
    } op_t;

    logic [36:0] q[$];

    always #5 CLK = ~CLK;

    shift_unit_pipe #(.TAG_W(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .InValid  (InValid),
        .InReady  (InReady),
        .ShIn     (ShIn),
        .Sh       (Sh),
        .ShReg    (ShReg),
        .Shamt5   (Shamt5),
        .RsAmt    (RsAmt),
        .CFlag    (CFlag),
        .InTag    (InTag),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ShOut    (ShOut),
        .ShCarry  (ShCarry),
        .OutTag   (OutTag)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(logic [31:0] x, logic [1:0] sh,
                               logic isReg, logic [4:0] n,
                               logic [7:0] a, logic cf, logic [3:0] tag);
        op_t o;
        o.x = x; o.sh = sh; o.isReg = isReg; o.n = n;
        o.a = a; o.cf = cf; o.tag = tag;
        return o;
    endfunction

    // Returns {carry, result} straight from the ARM shift rules.
    function automatic logic [32:0] model(op_t o);
        logic [31:0] x;
        logic [31:0] r;
        int n;
        x = o.x;
        if (!o.isReg) begin
            n = int'(o.n);
            if (n == 0) begin
                case (o.sh)
                    2'd0: return {o.cf, x};
                    2'd1: return {x[31], 32'h0};
                    2'd2: return {x[31], {32{x[31]}}};
                    default: begin
`ifdef SHIFTER_RRX_EN
                        return {x[0], o.cf, x[31:1]};
`else
                        return {o.cf, x};
`endif
                    end
                endcase
            end
        end else begin
            n = int'(o.a);
            if (n == 0) return {o.cf, x};
            if (o.sh == 2'd3) begin
                n = n % 32;
                if (n == 0) return {x[31], x};
            end else if (n >= 32) begin
                case (o.sh)
                    2'd0: return (n == 32) ? {x[0], 32'h0} : 33'h0;
                    2'd1: return (n == 32) ? {x[31], 32'h0} : 33'h0;
                    default: return {x[31], {32{x[31]}}};
                endcase
            end
        end
        case (o.sh)
            2'd0: return {x[32-n], x << n};
            2'd1: return {x[n-1], x >> n};
            2'd2: begin
                r = 32'($signed(x) >>> n);
                return {x[n-1], r};
            end
            default: begin
                r = (x >> n) | (x << (32 - n));
                return {r[31], r};
            end
        endcase
    endfunction

    // One clock: drive at negedge, then score what the next edge transfers.
    task automatic step(logic inV, op_t o, logic outR);
        logic [36:0] e;
        @(negedge CLK);
        InValid  = inV;
        ShIn     = o.x;
        Sh       = o.sh;
        ShReg    = o.isReg;
        Shamt5   = o.n;
        RsAmt    = o.a;
        CFlag    = o.cf;
        InTag    = o.tag;
        OutReady = outR;
        #1;
        if (OutValid && OutReady) begin
            if (q.size() == 0) begin
                check("spurious", {63'd0, OutValid}, 64'd0);
            end else begin
                e = q.pop_front();
                check("result", {27'd0, OutTag, ShCarry, ShOut},
                      {27'd0, e});
            end
        end
        if (InValid && InReady) begin
            q.push_back({o.tag, model(o)});
        end
    endtask

    task automatic single(string name, op_t o);
        op_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        step(1'b1, o, 1'b1);
        check({name, "_acc"}, {63'd0, InReady}, 64'd1);
        step(1'b0, idle, 1'b1);
        check({name, "_lat1"}, {63'd0, OutValid}, 64'd0);
        step(1'b0, idle, 1'b1);
        check({name, "_lat2"}, {63'd0, OutValid}, 64'd1);
        check({name, "_val"}, {31'd0, ShCarry, ShOut},
              {31'd0, model(o)});
    endtask

    task automatic drain();
        op_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            step(1'b0, idle, 1'b1);
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    function automatic op_t rndOp(logic [3:0] tag);
        op_t o;
        logic [7:0] aList [8];
        aList = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd16};
        o.x     = $urandom;
        o.sh    = 2'($urandom_range(0, 3));
        o.isReg = 1'($urandom_range(0, 1));
        o.n     = ($urandom_range(0, 3) == 0) ? 5'd0
                                              : 5'($urandom_range(0, 31));
        o.a     = ($urandom_range(0, 1) == 0) ? aList[$urandom_range(0, 7)]
                                              : 8'($urandom);
        o.cf    = 1'($urandom_range(0, 1));
        o.tag   = tag;
        return o;
    endfunction

    initial begin
        op_t idle;
        logic [36:0] snap;
        idle     = mk(0, 0, 0, 0, 0, 0, 0);
        RESET    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        ShIn     = 0;
        Sh       = 0;
        ShReg    = 0;
        Shamt5   = 0;
        RsAmt    = 0;
        CFlag    = 0;
        InTag    = 0;
        #1;
        check("rstOut", {27'd0, OutTag, ShCarry, ShOut}, 64'd0);
        check("rstValid", {63'd0, OutValid}, 64'd0);
        check("rstReady", {63'd0, InReady}, 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("relReady0", {63'd0, InReady}, 64'd0);
        @(posedge CLK);
        #1;
        check("relReady1", {63'd0, InReady}, 64'd1);

        single("lslImm", mk(32'h8000_0001, 2'd0, 0, 5'd1, 0, 0, 4'h1));
        single("lsr32", mk(32'h8000_0000, 2'd1, 0, 5'd0, 0, 0, 4'h2));
        single("asr32", mk(32'h8000_0000, 2'd2, 0, 5'd0, 0, 0, 4'h3));
        single("rrx", mk(32'h0000_0003, 2'd3, 0, 5'd0, 0, 1, 4'h4));
        single("lslR32", mk(32'h1, 2'd0, 1, 0, 8'd32, 0, 4'h5));
        single("lslR33", mk(32'h1, 2'd0, 1, 0, 8'd33, 0, 4'h6));
        single("rorR64", mk(32'h1, 2'd3, 1, 0, 8'd64, 0, 4'h7));
        single("asrR0", mk(32'h1, 2'd2, 1, 0, 8'd0, 1, 4'h8));
        single("rorImm", mk(32'h0000_00F1, 2'd3, 0, 5'd4, 0, 0, 4'h9));
        drain();

        // Backpressure: three cycles with OutReady low.
        step(1'b1, mk(32'h1234_5678, 2'd0, 0, 5'd4, 0, 0, 4'hA), 1'b0);
        step(1'b1, mk(32'h8765_4321, 2'd1, 0, 5'd8, 0, 0, 4'hB), 1'b0);
        step(1'b1, mk(32'hF000_000F, 2'd2, 1, 0, 8'd3, 0, 4'hC), 1'b0);
        check("bpReady", {63'd0, InReady}, 64'd0);
        check("bpValid", {63'd0, OutValid}, 64'd1);
        snap = {OutTag, ShCarry, ShOut};
        step(1'b1, mk(32'hF000_000F, 2'd2, 1, 0, 8'd3, 0, 4'hC), 1'b1);
        check("bpHold", {27'd0, OutTag, ShCarry, ShOut}, {27'd0, snap});
        check("bpResume", {63'd0, InReady}, 64'd1);
        step(1'b1, mk(32'h0F0F_0F0F, 2'd3, 1, 0, 8'd12, 1, 4'hD), 1'b1);
        drain();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), rndOp(4'(i)),
                 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Reset with both stages full.
        step(1'b1, mk(32'hDEAD_BEEF, 2'd0, 0, 5'd3, 0, 0, 4'h1), 1'b0);
        step(1'b1, mk(32'hCAFE_F00D, 2'd1, 0, 5'd5, 0, 0, 4'h2), 1'b0);
        RESET   = 1'b1;
        InValid = 1'b0;
        #1;
        check("midRstValid", {63'd0, OutValid}, 64'd0);
        check("midRstOut", {32'd0, ShOut}, 64'd0);
        check("midRstReady", {63'd0, InReady}, 64'd0);
        q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, idle, 1'b1);
        end
        check("noStale", {63'd0, OutValid}, 64'd0);
        check("postRstReady", {63'd0, InReady}, 64'd1);
        single("afterRst", mk(32'h0000_0010, 2'd1, 1, 0, 8'd4, 0, 4'hE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Pipelined operand-2 shifter for the datapath, sitting directly upstream of the ALU Src2 input.
- Implements the full ARM shift semantics on a 32-bit operand: LSL, LSR, ASR, ROR and RRX, with both immediate and register-specified amounts.
- Produces the shifted operand and the shifter carry-out.
- Two register stages with valid/ready handshake on both sides; full throughput, latency 2.

Parameters:
- TAG_W, 4, width of the sideband tag (e.g. destination register index) carried alongside each operation.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- InValid  input  1  upstream presents an operation.
- InReady  output  1  block accepts an operation this cycle.
- ShIn  input  32  operand to shift.
- Sh  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- ShReg  input  1  0 = immediate amount (Shamt5), 1 = register amount (RsAmt).
- Shamt5  input  5  immediate shift amount.
- RsAmt  input  8  register amount, Rs[7:0].
- CFlag  input  1  current C flag, used for pass-through carry and RRX.
- InTag  input  TAG_W  sideband tag, passed through unchanged.
- OutValid  output  1  result valid.
- OutReady  input  1  downstream consumes the result.
- ShOut  output  32  shifted operand.
- ShCarry  output  1  shifter carry-out.
- OutTag  output  TAG_W  tag of the result.

Behaviour:
- Transfer occurs when Valid && Ready on that side.
- Stage 1 registers the decode:
  - effective type;
  - rotate amount 0..31;
  - special-case code (PASS, ZERO, SIGN, RRX, NORMAL);
  - ShIn, CFlag, tag.
- Stage 2 registers ShOut, ShCarry and OutTag. Outputs come only from stage-2 registers.
- Latency: a result appears with OutValid=1 exactly 2 cycles after acceptance, provided OutReady stays 1.
- Throughput: 1 operation per cycle.
- Stall and flow control:
  - Stage 2 holds while OutValid && !OutReady.
  - Stage 1 advances when stage 2 is empty or being consumed.
  - InReady = !S1Valid || stage-1 advance. This is combinational from OutReady; it must not depend on InValid.
- Output holding: ShOut, ShCarry and OutTag stay stable while OutValid && !OutReady.
- Immediate amounts (ShReg=0), n = Shamt5:
  - LSL n=0: ShOut = ShIn, C = CFlag.
  - LSL n>0: ShOut = ShIn << n, C = ShIn[32-n].
  - LSR n=0 (encodes #32): ShOut = 0, C = ShIn[31].
  - LSR n>0: C = ShIn[n-1].
  - ASR n=0 (encodes #32): ShOut = {32{ShIn[31]}}, C = ShIn[31].
  - ASR n>0: C = ShIn[n-1].
  - ROR n=0 = RRX: ShOut = {CFlag, ShIn[31:1]}, C = ShIn[0].
  - ROR n>0: C = ShOut[31].
- Register amounts (ShReg=1), a = RsAmt (0..255):
  - a=0, any type: ShOut = ShIn, C = CFlag.
  - LSL: a=32 gives 0 with C = ShIn[0]; a>32 gives 0 with C = 0.
  - LSR: a=32 gives 0 with C = ShIn[31]; a>32 gives 0 with C = 0.
  - ASR a≥32: sign fill, C = ShIn[31].
  - ROR with a[4:0]=0, a≠0: ShOut = ShIn, C = ShIn[31].
  - ROR otherwise: rotate by a[4:0], C = ShOut[31].
- Arithmetic rule: all shifts are derived from a single rotate-right plus fill mask; LSL by n is implemented as ROR by (32-n) mod 32 with the low n bits masked.
- Reset:
  - All valid flags clear.
  - ShOut=0, ShCarry=0, OutTag=0, OutValid=0.
  - InReady=1 one cycle after RESET deasserts. During reset, InReady=0.
  - In-flight operations are discarded when reset is asserted mid-operation.
- Simultaneous consume at output and accept at input in the same cycle: both happen, with no bubble.

Optional Feature:
- Macro: SHIFTER_RRX_EN.
- Defined: immediate ROR #0 performs RRX as specified above.
- Undefined: immediate ROR #0 is plain pass-through, ShOut = ShIn, C = CFlag.
- The CFlag port exists in both builds.

Decomposition:
- Shared package shift_pkg holds:
  - shift-type constants SH_LSL, SH_LSR, SH_ASR, SH_ROR;
  - the special-case enum (PASS, ZERO, SIGN, RRX, NORMAL);
  - the stage-1 struct typedef.
- One sub-module, rotr32: combinational 5-level rotate-right, inputs data[31:0] and amt[4:0], output 32 bits. Instantiated in stage 2.

Test Plan:
- LSL imm: ShIn=0x8000_0001, Sh=00, Shamt5=1, CFlag=0 -> ShOut=0x0000_0002, C=1, valid 2 cycles after accept.
- LSR/ASR #32 via Shamt5=0:
  - ShIn=0x8000_0000, LSR -> 0x0, C=1.
  - Same ShIn, ASR -> 0xFFFF_FFFF, C=1.
- RRX: ShIn=0x0000_0003, Sh=11, Shamt5=0, CFlag=1:
  - -> 0x8000_0001, C=1 with SHIFTER_RRX_EN defined.
  - -> 0x0000_0003, C=1 without it.
- Register amounts, ShIn=0x0000_0001:
  - LSL a=32 -> 0, C=1.
  - LSL a=33 -> 0, C=0.
  - ROR a=64 -> 0x0000_0001, C=0.
  - any type, a=0, CFlag=1 -> pass-through, C=1.
- Backpressure: stream 4 ops back-to-back, hold OutReady=0 for 3 cycles -> InReady drops after 2 accepted, OutValid holds, outputs stable, all 4 results delivered in order with correct tags.
- Reset mid-stream: assert RESET with both stages full -> OutValid=0, ShOut=0 immediately; no stale result after release.
